// File: rtl/collider_pkg.sv
// Shared types for the barrier collision engine: box payload, side indices, scan FSM states.
package collider_pkg;

  localparam int unsigned BOX_W  = 10;
  localparam int unsigned SIDE_L = 0;
  localparam int unsigned SIDE_R = 1;
  localparam int unsigned SIDE_T = 2;
  localparam int unsigned SIDE_B = 3;

  typedef struct packed {
    logic [BOX_W-1:0] x;
    logic [BOX_W-1:0] y;
    logic [BOX_W-1:0] hl;
    logic [BOX_W-1:0] hh;
  } box_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

endpackage

// File: rtl/box_overlap.sv
// Inclusive overlap test of a probe box against a target box grown by a margin,
// reporting which side of the target the probe centre lies beyond.
module box_overlap
  import collider_pkg::*;
(
  input  box_t             probe,
  input  box_t             target,
  input  logic [BOX_W-1:0] margin,
  output logic             hit,
  output logic [3:0]       side
);

  localparam int unsigned SW = BOX_W + 2;

  logic signed [SW-1:0] px, py, phl, phh, tl, tr, tt, tb, m;

  always_comb begin
    px  = $signed({2'b00, probe.x});
    py  = $signed({2'b00, probe.y});
    phl = $signed({2'b00, probe.hl});
    phh = $signed({2'b00, probe.hh});
    m   = $signed({2'b00, margin});
    tl  = $signed({2'b00, target.x}) - $signed({2'b00, target.hl});
    tr  = $signed({2'b00, target.x}) + $signed({2'b00, target.hl});
    tt  = $signed({2'b00, target.y}) - $signed({2'b00, target.hh});
    tb  = $signed({2'b00, target.y}) + $signed({2'b00, target.hh});

    hit = (px + phl >= tl - m) && (px - phl <= tr + m) &&
          (py + phh >= tt - m) && (py - phh <= tb + m);

    // Side bits only mean something on a hit; a centre inside the box sets none.
    side = '0;
    if (hit) begin
      side[SIDE_L] = (px < tl);
      side[SIDE_R] = (px > tr);
      side[SIDE_T] = (py < tt);
      side[SIDE_B] = (py > tb);
    end
  end

endmodule

// File: rtl/barrier_field_collider.sv
// Multi-barrier collision engine: scans a table of destructible barriers once per frame,
// one entry per clock, accumulating player side hits and bullet hits, and applying damage.
module barrier_field_collider
  import collider_pkg::*;
#(
  parameter int unsigned NUM_BARRIERS = 8,
  parameter int unsigned NUM_BULLETS  = 2,
  parameter int unsigned COORD_W      = BOX_W,
  parameter int unsigned HP_W         = 2,
  parameter int unsigned MARGIN       = 3
) (
  input  logic                                            Clk,
  input  logic                                            Reset,
  input  logic                                            frame_start,
  input  logic                                            wr_en,
  input  logic [$clog2(NUM_BARRIERS > 1 ? NUM_BARRIERS : 2)-1:0] wr_idx,
  input  logic [COORD_W-1:0]                              wr_x,
  input  logic [COORD_W-1:0]                              wr_y,
  input  logic [COORD_W-1:0]                              wr_hl,
  input  logic [COORD_W-1:0]                              wr_hh,
  input  logic [HP_W-1:0]                                 wr_hp,
  output logic                                            wr_ready,
  input  logic [COORD_W-1:0]                              BallX,
  input  logic [COORD_W-1:0]                              BallY,
  input  logic [COORD_W-1:0]                              Ball_Size,
  input  logic [NUM_BULLETS*COORD_W-1:0]                  BulletX,
  input  logic [NUM_BULLETS*COORD_W-1:0]                  BulletY,
  input  logic [NUM_BULLETS*COORD_W-1:0]                  Bullet_Size,
  output logic [3:0]                                      player_collision,
  output logic [NUM_BULLETS-1:0]                          bullet_collision,
  output logic [NUM_BARRIERS-1:0]                         barrier_alive,
  output logic                                            busy,
  output logic                                            done
);

  localparam int unsigned IDX_W = $clog2(NUM_BARRIERS > 1 ? NUM_BARRIERS : 2);

  state_t                  state, state_d;
  logic                    start, last;
  logic [IDX_W-1:0]        idx;
  box_t                    tbl [NUM_BARRIERS];
  logic [HP_W-1:0]         hp  [NUM_BARRIERS];
  box_t                    ball_q;
  box_t                    bullet_q [NUM_BULLETS];
  box_t                    cur;
  logic                    wr_ok, alive, dmg;
  logic                    player_hit;
  logic [3:0]              player_side;
  logic [3:0]              bullet_side_unused [NUM_BULLETS];
  logic [NUM_BULLETS-1:0]  bullet_raw;
  logic [3:0]              player_sh, player_acc;
  logic [NUM_BULLETS-1:0]  bullet_sh, bullet_acc;
  logic [NUM_BARRIERS-1:0] alive_next;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_d;
  end

  // Next state and scan control strobes.
  always_comb begin
    state_d = state;
    start   = 1'b0;
    last    = 1'b0;
    unique case (state)
      IDLE: if (frame_start) begin
        state_d = SCAN;
        start   = 1'b1;
      end
      SCAN: if (idx == IDX_W'(NUM_BARRIERS - 1)) begin
        state_d = DONE;
        last    = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ok      = wr_en && wr_ready;
    cur        = tbl[idx];
    alive      = (state == SCAN) && (hp[idx] != '0);
    dmg        = alive && (|bullet_raw);
    player_acc = player_sh | ((alive && player_hit) ? player_side : 4'b0000);
    bullet_acc = bullet_sh | (alive ? bullet_raw : '0);
    for (int i = 0; i < NUM_BARRIERS; i++)
      alive_next[i] = (hp[i] != '0) &&
                      !(dmg && (idx == IDX_W'(i)) && (hp[i] == HP_W'(1)));
  end

  box_overlap u_player (
    .probe  (ball_q),
    .target (cur),
    .margin (BOX_W'(MARGIN)),
    .hit    (player_hit),
    .side   (player_side)
  );

  for (genvar k = 0; k < NUM_BULLETS; k++) begin : g_bullet
    box_overlap u_bullet (
      .probe  (bullet_q[k]),
      .target (cur),
      .margin ('0),
      .hit    (bullet_raw[k]),
      .side   (bullet_side_unused[k])
    );
  end

  // Geometry table and per-frame input snapshot; HP lives with the reset logic below.
  always_ff @(posedge Clk) begin
    if (wr_ok)
      tbl[wr_idx] <= '{x: BOX_W'(wr_x), y: BOX_W'(wr_y), hl: BOX_W'(wr_hl), hh: BOX_W'(wr_hh)};
    if (start) begin
      ball_q <= '{x: BOX_W'(BallX), y: BOX_W'(BallY), hl: BOX_W'(Ball_Size), hh: BOX_W'(Ball_Size)};
      for (int k = 0; k < NUM_BULLETS; k++)
        bullet_q[k] <= '{x:  BOX_W'(BulletX[k*COORD_W +: COORD_W]),
                         y:  BOX_W'(BulletY[k*COORD_W +: COORD_W]),
                         hl: BOX_W'(Bullet_Size[k*COORD_W +: COORD_W]),
                         hh: BOX_W'(Bullet_Size[k*COORD_W +: COORD_W])};
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      idx              <= '0;
      player_sh        <= '0;
      bullet_sh        <= '0;
      player_collision <= '0;
      bullet_collision <= '0;
      barrier_alive    <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      wr_ready         <= 1'b1;
      for (int i = 0; i < NUM_BARRIERS; i++) hp[i] <= '0;
    end else begin
      busy     <= (state_d != IDLE);
      wr_ready <= (state_d == IDLE);
      done     <= (state_d == DONE);
      if (wr_ok) hp[wr_idx] <= wr_hp;
      if (start) begin
        idx       <= '0;
        player_sh <= '0;
        bullet_sh <= '0;
      end else if (state == SCAN) begin
        if (!last) idx <= idx + IDX_W'(1);
        player_sh <= player_acc;
        bullet_sh <= bullet_acc;
        if (dmg) hp[idx] <= hp[idx] - HP_W'(1);
      end
      // Results publish together with the last entry's contribution, visible during DONE.
      if (last) begin
        player_collision <= player_acc;
        bullet_collision <= bullet_acc;
        barrier_alive    <= alive_next;
      end
    end
  end

endmodule

// File: tb/tb_barrier_field_collider.sv
// Directed bench for barrier_field_collider: table-driven player side vectors plus
// hand-written bullet damage, busy, and mid-scan reset sequences.
module tb_barrier_field_collider;

  localparam int NB = 8;
  localparam int CW = 10;

  logic           Clk = 1'b0;
  logic           Reset;
  logic           frame_start, wr_en, wr_ready;
  logic [2:0]     wr_idx;
  logic [CW-1:0]  wr_x, wr_y, wr_hl, wr_hh;
  logic [1:0]     wr_hp;
  logic [CW-1:0]  BallX, BallY, Ball_Size;
  logic [2*CW-1:0] BulletX, BulletY, Bullet_Size;
  logic [3:0]     player_collision;
  logic [1:0]     bullet_collision;
  logic [NB-1:0]  barrier_alive;
  logic           busy, done;

  int assertions = 0;
  int failures   = 0;

  barrier_field_collider dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_x(wr_x), .wr_y(wr_y),
    .wr_hl(wr_hl), .wr_hh(wr_hh), .wr_hp(wr_hp), .wr_ready(wr_ready),
    .BallX(BallX), .BallY(BallY), .Ball_Size(Ball_Size),
    .BulletX(BulletX), .BulletY(BulletY), .Bullet_Size(Bullet_Size),
    .player_collision(player_collision), .bullet_collision(bullet_collision),
    .barrier_alive(barrier_alive), .busy(busy), .done(done)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    assertions++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_ball(input int x, input int y);
    BallX = CW'(x);
    BallY = CW'(y);
  endtask

  task automatic set_bullet(input int k, input int x, input int y);
    BulletX[k*CW +: CW] = CW'(x);
    BulletY[k*CW +: CW] = CW'(y);
  endtask

  task automatic wr(input int i, input int x, input int y, input int hl, input int hh, input int h);
    wr_idx = 3'(i); wr_x = CW'(x); wr_y = CW'(y); wr_hl = CW'(hl); wr_hh = CW'(hh); wr_hp = 2'(h);
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  // Called one edge after the frame_start edge; lat counts edges since frame_start was sampled.
  task automatic wait_done(output int lat);
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    tick();
    chk("done_pulse_width", 32'(done), 32'd0);
  endtask

  task automatic frame(output int lat);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    wait_done(lat);
  endtask

  typedef struct {
    string      name;
    int         bx, by;
    logic [3:0] pc;
  } vec_t;

  vec_t vecs [9];
  int   lat, pulses;
  logic [3:0] pc_seen;

  initial begin
    vecs[0] = '{"left",         225, 240, 4'b0001};
    vecs[1] = '{"right",        255, 240, 4'b0010};
    vecs[2] = '{"top",          240, 221, 4'b0100};
    vecs[3] = '{"bottom",       240, 259, 4'b1000};
    vecs[4] = '{"corner_lt",    226, 226, 4'b0101};
    vecs[5] = '{"corner_rb",    254, 254, 4'b1010};
    vecs[6] = '{"miss_left",    220, 240, 4'b0000};
    vecs[7] = '{"miss_right",   260, 240, 4'b0000};
    vecs[8] = '{"centre_in",    240, 240, 4'b0000};

    Reset = 1'b1; frame_start = 1'b0; wr_en = 1'b0;
    wr_idx = '0; wr_x = '0; wr_y = '0; wr_hl = '0; wr_hh = '0; wr_hp = '0;
    Ball_Size = CW'(4);
    Bullet_Size = {CW'(2), CW'(2)};
    set_ball(160, 80);
    set_bullet(0, 0, 0);
    set_bullet(1, 0, 0);
    repeat (2) tick();

    chk("rst_player", 32'(player_collision), 0);
    chk("rst_bullet", 32'(bullet_collision), 0);
    chk("rst_alive",  32'(barrier_alive), 0);
    chk("rst_busy",   32'(busy), 0);
    chk("rst_done",   32'(done), 0);
    chk("rst_wr_ready", 32'(wr_ready), 1);
    Reset = 1'b0;
    tick();

    frame(lat);
    chk("empty_latency", 32'(lat), NB + 1);
    chk("empty_player",  32'(player_collision), 0);
    chk("empty_bullet",  32'(bullet_collision), 0);
    chk("empty_alive",   32'(barrier_alive), 0);

    wr(0, 240, 240, 12, 12, 2);
    for (int v = 0; v < 9; v++) begin
      set_ball(vecs[v].bx, vecs[v].by);
      frame(lat);
      chk({vecs[v].name, "_latency"}, 32'(lat), NB + 1);
      chk({vecs[v].name, "_player"},  32'(player_collision), 32'(vecs[v].pc));
      chk({vecs[v].name, "_bullet"},  32'(bullet_collision), 0);
      chk({vecs[v].name, "_alive"},   32'(barrier_alive), 32'h01);
    end
    set_ball(160, 80);

    // Single bullet wears barrier 0 down from 2 HP over two frames.
    set_bullet(0, 240, 240);
    frame(lat);
    chk("b0_f1_bullet", 32'(bullet_collision), 1);
    chk("b0_f1_alive",  32'(barrier_alive), 32'h01);
    frame(lat);
    chk("b0_f2_bullet", 32'(bullet_collision), 1);
    frame(lat);
    chk("b0_f3_bullet", 32'(bullet_collision), 0);
    chk("b0_f3_alive",  32'(barrier_alive), 0);
    set_ball(240, 259);
    frame(lat);
    chk("dead_player", 32'(player_collision), 0);
    set_ball(160, 80);

    // Two bullets in one frame cost only one HP.
    wr(0, 240, 240, 12, 12, 2);
    set_bullet(1, 240, 240);
    frame(lat);
    chk("dual_bullet", 32'(bullet_collision), 32'h3);
    chk("dual_alive",  32'(barrier_alive), 32'h01);
    set_bullet(0, 0, 0);
    set_bullet(1, 0, 0);
    frame(lat);
    chk("dual_after_bullet", 32'(bullet_collision), 0);
    chk("dual_after_alive",  32'(barrier_alive), 32'h01);
    set_bullet(0, 240, 240);
    set_bullet(1, 240, 240);
    frame(lat);
    chk("dual_kill_bullet", 32'(bullet_collision), 32'h3);
    chk("dual_kill_alive",  32'(barrier_alive), 0);
    set_bullet(0, 0, 0);
    set_bullet(1, 0, 0);

    // Bullet edge: right edge of bullet exactly on barrier left edge counts, one short does not.
    wr(0, 240, 240, 12, 12, 2);
    set_bullet(0, 225, 240);
    frame(lat);
    chk("bedge_miss", 32'(bullet_collision), 0);
    set_bullet(0, 226, 240);
    frame(lat);
    chk("bedge_hit", 32'(bullet_collision), 1);
    set_bullet(0, 0, 0);

    // Busy: write dropped, second frame_start ignored, ball change mid-scan ignored.
    wr(0, 240, 240, 12, 12, 2);
    set_ball(225, 240);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("busy_flag", 32'(busy), 1);
    chk("busy_wr_ready", 32'(wr_ready), 0);
    wr(1, 160, 80, 12, 12, 3);
    frame_start = 1'b1;
    set_ball(255, 240);
    tick();
    frame_start = 1'b0;
    pulses = 0;
    pc_seen = 4'hF;
    for (int c = 0; c < 24; c++) begin
      if (done === 1'b1) begin
        pulses++;
        pc_seen = player_collision;
      end
      tick();
    end
    chk("busy_done_pulses", 32'(pulses), 1);
    chk("busy_player", 32'(pc_seen), 32'h1);
    set_ball(160, 80);
    frame(lat);
    chk("dropped_write_player", 32'(player_collision), 0);
    chk("dropped_write_alive",  32'(barrier_alive), 32'h01);

    // Reset partway through the scan.
    set_ball(225, 240);
    frame(lat);
    chk("pre_reset_player", 32'(player_collision), 1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b1;
    #1;
    chk("mid_rst_player", 32'(player_collision), 0);
    chk("mid_rst_alive",  32'(barrier_alive), 0);
    chk("mid_rst_busy",   32'(busy), 0);
    chk("mid_rst_done",   32'(done), 0);
    chk("mid_rst_wr_ready", 32'(wr_ready), 1);
    tick();
    Reset = 1'b0;
    pulses = 0;
    for (int c = 0; c < 14; c++) begin
      if (done === 1'b1) pulses++;
      tick();
    end
    chk("post_rst_no_done", 32'(pulses), 0);
    frame(lat);
    chk("post_rst_latency", 32'(lat), NB + 1);
    chk("post_rst_player",  32'(player_collision), 0);
    chk("post_rst_alive",   32'(barrier_alive), 0);

    // Write in the same cycle as frame_start is seen by that scan.
    wr_idx = 3'd2; wr_x = CW'(240); wr_y = CW'(240); wr_hl = CW'(12); wr_hh = CW'(12); wr_hp = 2'd1;
    wr_en = 1'b1;
    frame_start = 1'b1;
    tick();
    wr_en = 1'b0;
    frame_start = 1'b0;
    wait_done(lat);
    chk("wr_start_latency", 32'(lat), NB + 1);
    chk("wr_start_player",  32'(player_collision), 1);
    chk("wr_start_alive",   32'(barrier_alive), 32'h04);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
